// File: rtl/mic_volume_meter_pkg.sv
// Shared constants, FSM encoding and the amplitude-to-level quantiser used by
// the microphone volume meter.
package mic_volume_meter_pkg;

   localparam int unsigned MIC_W           = 12;
   localparam int unsigned VOL_W           = 4;
   localparam int unsigned MIC_MID_DEFAULT = 2048;
   localparam int unsigned LEVEL_MAX       = 15;
   localparam int unsigned CNT_W           = 16;

   typedef enum logic [1:0] {
      ST_ACCUM  = 2'd0,
      ST_QUANT  = 2'd1,
      ST_UPDATE = 2'd2
   } meter_state_e;

   // Shift the peak down to a bar level; anything above the top bar pins to it.
   function automatic logic [VOL_W-1:0] quant_level(input logic [MIC_W-1:0] amp,
                                                   input int unsigned       shift);
      logic [MIC_W-1:0] scaled;
      scaled = amp >> shift;
      if (scaled > MIC_W'(LEVEL_MAX))
         return VOL_W'(LEVEL_MAX);
      return scaled[VOL_W-1:0];
   endfunction

endpackage

// File: rtl/mic_volume_meter_abs_amp.sv
// Absolute deviation of a mic sample from the mid-scale code.
module mic_abs_amp
   import mic_volume_meter_pkg::*;
#(
   parameter int unsigned MID = MIC_MID_DEFAULT
) (
   input  logic [MIC_W-1:0] mic_i,
   output logic [MIC_W-1:0] amp_o
);

   localparam logic [MIC_W-1:0] MID_C = MIC_W'(MID);

   // Code 0 yields MID itself (2048), which still fits in MIC_W bits.
   always_comb begin
      amp_o = '0;
      if (mic_i >= MID_C)
         amp_o = mic_i - MID_C;
      else
         amp_o = MID_C - mic_i;
   end

endmodule

// File: rtl/mic_volume_meter.sv
// Windowed peak meter: tracks peak deviation over WINDOW samples, quantises it
// to a 0..15 bar level and applies instant-attack / fall-by-one decay.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_ACCUM  | idle between window results; sampling always continues
// ST_QUANT  | one cycle: quantise the just-captured peak into level_q
// ST_UPDATE | one cycle: apply attack/decay to vol (unless frozen), pulse
module mic_volume_meter
   import mic_volume_meter_pkg::*;
#(
   parameter int unsigned WINDOW = 4000,
   parameter int unsigned MID    = MIC_MID_DEFAULT,
   parameter int unsigned SHIFT  = 7
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sample_en,
   input  logic [MIC_W-1:0] mic_in,
   input  logic             freeze,
   output logic [VOL_W-1:0] vol,
   output logic             vol_valid,
   output logic [MIC_W-1:0] peak
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);

   meter_state_e     state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [MIC_W-1:0] run_max_q;
   logic [MIC_W-1:0] peak_q;
   logic [VOL_W-1:0] level_q;
   logic [VOL_W-1:0] vol_q;
   logic             vol_valid_q;

   logic [MIC_W-1:0] amp;
   logic [MIC_W-1:0] run_max_d;
   logic [VOL_W-1:0] vol_d;
   logic             win_done;

   mic_abs_amp #(
      .MID (MID)
   ) u_abs_amp (
      .mic_i (mic_in),
      .amp_o (amp)
   );

   always_comb begin
      run_max_d = (amp > run_max_q) ? amp : run_max_q;
      win_done  = sample_en && (cnt_q == CNT_LAST);
      vol_d     = vol_q;
      if (!freeze) begin
         if (level_q >= vol_q)
            vol_d = level_q;
         else
            vol_d = vol_q - 1'b1;
      end
   end

   // Sampling runs independently of the result states so no sample is lost;
   // WINDOW >= 2 guarantees the next window cannot close before QUANT is done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_ACCUM;
         cnt_q       <= '0;
         run_max_q   <= '0;
         peak_q      <= '0;
         level_q     <= '0;
         vol_q       <= '0;
         vol_valid_q <= 1'b0;
      end else begin
         vol_valid_q <= 1'b0;

         if (sample_en) begin
            if (win_done) begin
               peak_q    <= run_max_d;
               run_max_q <= '0;
               cnt_q     <= '0;
            end else begin
               run_max_q <= run_max_d;
               cnt_q     <= cnt_q + 1'b1;
            end
         end

         unique case (state_q)
            ST_ACCUM: begin
               if (win_done)
                  state_q <= ST_QUANT;
            end
            ST_QUANT: begin
               level_q <= quant_level(peak_q, SHIFT);
               state_q <= ST_UPDATE;
            end
            ST_UPDATE: begin
               vol_q       <= vol_d;
               vol_valid_q <= 1'b1;
               state_q     <= win_done ? ST_QUANT : ST_ACCUM;
            end
            default: begin
               state_q <= ST_ACCUM;
            end
         endcase
      end
   end

   assign vol       = vol_q;
   assign vol_valid = vol_valid_q;
   assign peak      = peak_q;

endmodule

// File: tb/tb_mic_volume_meter.sv
// Directed and randomised bench for mic_volume_meter against a window-level
// reference model.
module tb_mic_volume_meter;

   localparam int WINDOW = 4;
   localparam int SHIFT  = 7;
   localparam int MID    = 2048;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sample_en;
   logic [11:0] mic_in;
   logic        freeze;
   logic [3:0]  vol;
   logic        vol_valid;
   logic [11:0] peak;

   int n_vec = 0;
   int n_err = 0;

   // reference model state
   int m_samples[$];
   int m_peak;
   int m_vol;
   bit m_valid;
   int m_due[$];
   int m_lvl[$];
   int t_now;
   int pulses;

   always #5 clk = ~clk;

   mic_volume_meter #(
      .WINDOW (WINDOW),
      .MID    (MID),
      .SHIFT  (SHIFT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sample_en (sample_en),
      .mic_in    (mic_in),
      .freeze    (freeze),
      .vol       (vol),
      .vol_valid (vol_valid),
      .peak      (peak)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      m_samples.delete();
      m_due.delete();
      m_lvl.delete();
      m_peak  = 0;
      m_vol   = 0;
      m_valid = 0;
   endtask

   function automatic int abs_amp(input int s);
      return (s >= MID) ? s - MID : MID - s;
   endfunction

   // One clock: drive inputs, advance the model at the edge, compare just after.
   task automatic step(input bit en, input int smp, input bit frz);
      int lvl;
      int mx;
      sample_en = en;
      mic_in    = 12'(smp);
      freeze    = frz;
      @(posedge clk);
      t_now++;
      m_valid = 0;
      if (m_due.size() > 0 && m_due[0] == t_now) begin
         void'(m_due.pop_front());
         lvl = m_lvl.pop_front();
         m_valid = 1;
         if (!frz)
            m_vol = (lvl >= m_vol) ? lvl : m_vol - 1;
      end
      if (en) begin
         m_samples.push_back(abs_amp(smp));
         if (m_samples.size() == WINDOW) begin
            mx = 0;
            foreach (m_samples[i]) if (m_samples[i] > mx) mx = m_samples[i];
            m_peak = mx;
            m_samples.delete();
            lvl = mx / (1 << SHIFT);
            if (lvl > 15) lvl = 15;
            m_due.push_back(t_now + 2);
            m_lvl.push_back(lvl);
         end
      end
      #1;
      chk("peak", peak, m_peak);
      chk("vol", vol, m_vol);
      chk("vol_valid", vol_valid, m_valid);
      if (vol_valid === 1'b1) pulses++;
   endtask

   task automatic window4(input int s0, input int s1, input int s2, input int s3);
      step(1, s0, 0);
      step(1, s1, 0);
      step(1, s2, 0);
      step(1, s3, 0);
      step(0, 0, 0);
      step(0, 0, 0);
   endtask

   initial begin
      int p0;
      int v_before;
      int smp;
      rst_n     = 1'b0;
      sample_en = 1'b0;
      mic_in    = '0;
      freeze    = 1'b0;
      t_now     = 0;
      pulses    = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_peak", peak, 0);
      chk("rst_vol", vol, 0);
      chk("rst_valid", vol_valid, 0);
      rst_n = 1'b1;

      // 1: quiet window after reset
      p0 = pulses;
      window4(2048, 2048, 2048, 2048);
      chk("s1_peak", peak, 0);
      chk("s1_vol", vol, 0);
      chk("s1_pulses", pulses - p0, 1);

      // 2: attack
      window4(2048, 3000, 2048, 2048);
      chk("s2_peak", peak, 952);
      chk("s2_vol", vol, 7);

      // 3: negative full swing saturates
      window4(0, 2048, 2048, 2048);
      chk("s3_peak", peak, 2048);
      chk("s3_vol", vol, 15);

      // 4: decay by one per quiet window
      window4(2048, 2048, 2048, 2048);
      chk("s4_vol_a", vol, 14);
      window4(2048, 2048, 2048, 2048);
      chk("s4_vol_b", vol, 13);
      window4(2048, 2048, 2048, 2048);
      chk("s4_vol_c", vol, 12);

      // 5: back-to-back strobes, freeze over the second result
      p0 = pulses;
      v_before = 0;
      for (int i = 1; i <= 12; i++) begin
         step(1, 3000, (i >= 9 && i <= 11));
         if (i == 6) chk("s5_vol_first", vol, 11);
         if (i == 9) v_before = vol;
         if (i == 10) begin
            chk("s5_frozen_pulse", vol_valid, 1);
            chk("s5_frozen_vol", vol, v_before);
         end
      end
      step(0, 0, 0);
      step(0, 0, 0);
      chk("s5_pulses", pulses - p0, 3);
      chk("s5_vol_last", vol, 10);

      // 6: reset in the middle of a window
      step(1, 4095, 0);
      step(1, 4095, 0);
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("s6_peak", peak, 0);
      chk("s6_vol", vol, 0);
      chk("s6_valid", vol_valid, 0);
      #3;
      rst_n = 1'b1;
      window4(2048, 2048, 2048, 2048);
      chk("s6_peak_after", peak, 0);
      chk("s6_vol_after", vol, 0);

      // randomised traffic: mix of quiet, moderate and loud samples
      for (int i = 0; i < 3000; i++) begin
         case ($urandom_range(0, 2))
            0:       smp = MID - 40 + int'($urandom_range(0, 80));
            1:       smp = MID - 700 + int'($urandom_range(0, 1400));
            default: smp = int'($urandom_range(0, 4095));
         endcase
         step($urandom_range(0, 3) != 0, smp, $urandom_range(0, 3) == 0);
      end
      repeat (3) step(0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
